// File: rtl/bert_defs_pkg.sv
// Shared BERT definitions: pattern and FSM encodings, LFSR taps, default seed, helpers.
// Used by the pattern generator and by the receive-side error counter.
package bert_defs_pkg;

  typedef enum logic [1:0] {
    PAT_PRBS7  = 2'b00,
    PAT_PRBS9  = 2'b01,
    PAT_PRBS15 = 2'b10,
    PAT_ALT    = 2'b11
  } pattern_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } bert_state_e;

  localparam int LFSR_W = 15;
  localparam int CNT_W  = 16;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 15'h7FFF;
  localparam logic [CNT_W-1:0]  CNT_MAX      = 16'hFFFF;

  localparam int PRBS7_TAP_HI  = 6;
  localparam int PRBS7_TAP_LO  = 5;
  localparam int PRBS9_TAP_HI  = 8;
  localparam int PRBS9_TAP_LO  = 4;
  localparam int PRBS15_TAP_HI = 14;
  localparam int PRBS15_TAP_LO = 13;

  // Active register bits for each pattern; the alternating pattern lives in bit 0 only.
  function automatic logic [LFSR_W-1:0] pattern_mask(input pattern_e sel);
    logic [LFSR_W-1:0] m;
    case (sel)
      PAT_PRBS7:  m = 15'h007F;
      PAT_PRBS9:  m = 15'h01FF;
      PAT_PRBS15: m = 15'h7FFF;
      default:    m = 15'h0001;
    endcase
    return m;
  endfunction

  // A PRBS register must never load all-zero (it would lock up), so fall back to all-ones.
  function automatic logic [LFSR_W-1:0] seed_value(input pattern_e sel,
                                                   input logic [LFSR_W-1:0] seed);
    logic [LFSR_W-1:0] m;
    logic [LFSR_W-1:0] v;
    m = pattern_mask(sel);
    v = seed & m;
    if (sel == PAT_ALT) begin
      v = '0;
    end else if (v == '0) begin
      v = m;
    end
    return v;
  endfunction

  function automatic logic lfsr_feedback(input pattern_e sel, input logic [LFSR_W-1:0] s);
    logic f;
    case (sel)
      PAT_PRBS7:  f = s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO];
      PAT_PRBS9:  f = s[PRBS9_TAP_HI] ^ s[PRBS9_TAP_LO];
      PAT_PRBS15: f = s[PRBS15_TAP_HI] ^ s[PRBS15_TAP_LO];
      default:    f = ~s[0];
    endcase
    return f;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/bert_lfsr.sv
// Multi-pattern LFSR (PRBS7/9/15 or 1010 toggle); load has priority over shift.
// fb is combinational from the current state; state updates one edge after load/shift.
module bert_lfsr
  import bert_defs_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RESET_STATE = DEFAULT_SEED
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  pattern_e          sel,
  input  logic [LFSR_W-1:0] seed,
  output logic              fb,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  assign fb    = lfsr_feedback(sel, lfsr_q);
  assign state = lfsr_q;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = seed_value(sel, seed);
    end else if (shift) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], fb} & pattern_mask(sel);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr_q <= RESET_STATE;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/bert_pattern_tx.sv
// BERT transmit pattern generator with manual and periodic single-bit error injection.
// First valid bit two edges after enable is sampled high; no backpressure, one bit per cycle.
module bert_pattern_tx
  import bert_defs_pkg::*;
#(
  parameter logic [LFSR_W-1:0] INIT_SEED = DEFAULT_SEED
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       pattern_sel,
  input  logic             inject_req,
  input  logic [CNT_W-1:0] inject_period,
  output logic             tx_data,
  output logic             ref_data,
  output logic             tx_valid,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] inject_count,
  output logic             count_full
);

  bert_state_e      state_q, state_d;
  pattern_e         sel_q, sel_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;
  logic [CNT_W-1:0] inject_count_q, inject_count_d;
  logic             req_q, req_d;
  logic             tx_data_q, tx_data_d;
  logic             ref_data_q, ref_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             count_full_q, count_full_d;
  logic             inj_manual, inj_periodic, inj;

  pattern_e          lfsr_sel;
  logic              lfsr_load;
  logic              lfsr_shift;
  logic              lfsr_fb;
  logic [LFSR_W-1:0] lfsr_state_unused;

  // The LFSR loads with the live select at RUN entry and uses the latched one while running.
  assign lfsr_sel   = (state_q == ST_IDLE) ? pattern_e'(pattern_sel) : sel_q;
  assign lfsr_load  = (state_q == ST_IDLE) && enable;
  assign lfsr_shift = (state_q == ST_RUN) && enable;

  bert_lfsr #(
    .RESET_STATE(INIT_SEED)
  ) u_lfsr (
    .clock(clock),
    .reset(reset),
    .load (lfsr_load),
    .shift(lfsr_shift),
    .sel  (lfsr_sel),
    .seed (INIT_SEED),
    .fb   (lfsr_fb),
    .state(lfsr_state_unused)
  );

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    period_d       = period_q;
    per_cnt_d      = per_cnt_q;
    req_d          = inject_req;
    tx_valid_d     = 1'b0;
    tx_data_d      = 1'b0;
    ref_data_d     = 1'b0;
    bit_count_d    = bit_count_q;
    inject_count_d = inject_count_q;
    inj_manual     = 1'b0;
    inj_periodic   = 1'b0;
    inj            = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d   = ST_RUN;
          sel_d     = lfsr_sel;
          period_d  = inject_period;
          per_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else begin
          if (period_q != '0) begin
            per_cnt_d    = (per_cnt_q == period_q) ? 16'd1 : per_cnt_q + 16'd1;
            inj_periodic = (per_cnt_d == period_q);
          end
          inj_manual     = inject_req & ~req_q;
          // Coincident manual and periodic requests collapse into one inversion.
          inj            = inj_manual | inj_periodic;
          ref_data_d     = lfsr_fb;
          tx_data_d      = lfsr_fb ^ inj;
          tx_valid_d     = 1'b1;
          bit_count_d    = sat_inc(bit_count_q);
          inject_count_d = inj ? sat_inc(inject_count_q) : inject_count_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    count_full_d = count_full_q | (bit_count_d == CNT_MAX) | (inject_count_d == CNT_MAX);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      sel_q          <= PAT_PRBS7;
      period_q       <= '0;
      per_cnt_q      <= '0;
      req_q          <= 1'b0;
      tx_data_q      <= 1'b0;
      ref_data_q     <= 1'b0;
      tx_valid_q     <= 1'b0;
      bit_count_q    <= '0;
      inject_count_q <= '0;
      count_full_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      period_q       <= period_d;
      per_cnt_q      <= per_cnt_d;
      req_q          <= req_d;
      tx_data_q      <= tx_data_d;
      ref_data_q     <= ref_data_d;
      tx_valid_q     <= tx_valid_d;
      bit_count_q    <= bit_count_d;
      inject_count_q <= inject_count_d;
      count_full_q   <= count_full_d;
    end
  end

  assign tx_data      = tx_data_q;
  assign ref_data     = ref_data_q;
  assign tx_valid     = tx_valid_q;
  assign bit_count    = bit_count_q;
  assign inject_count = inject_count_q;
  assign count_full   = count_full_q;

endmodule

// File: tb/tb_bert_pattern_tx.sv
// Directed bench for bert_pattern_tx: patterns, injection, enable/reset handling, saturation.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bert_pattern_tx;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'b00;
  logic        inject_req = 1'b0;
  logic [15:0] inject_period = 16'd0;
  logic        tx_data, ref_data, tx_valid, count_full;
  logic [15:0] bit_count, inject_count;

  int n_vec = 0;
  int n_err = 0;
  int exp_bits = 0;
  int exp_inj = 0;
  int n_invalid = 0;
  logic [255:0] tv, rv;

  always #5 clock = ~clock;

  bert_pattern_tx #(
    .INIT_SEED(15'h7FFF)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .pattern_sel  (pattern_sel),
    .inject_req   (inject_req),
    .inject_period(inject_period),
    .tx_data      (tx_data),
    .ref_data     (ref_data),
    .tx_valid     (tx_valid),
    .bit_count    (bit_count),
    .inject_count (inject_count),
    .count_full   (count_full)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic take_bit(output logic t, output logic r, output logic v);
    @(negedge clock);
    t = tx_data;
    r = ref_data;
    v = tx_valid;
    if (exp_bits < 65535) exp_bits++;
  endtask

  task automatic capture(input int n, input logic [255:0] req_pat);
    logic t, r, v;
    for (int i = 0; i < n; i++) begin
      inject_req = req_pat[i];
      take_bit(t, r, v);
      tv[i] = t;
      rv[i] = r;
      if (!v) n_invalid++;
    end
    inject_req = 1'b0;
  endtask

  task automatic start_run(input string tag, input logic [1:0] sel, input logic [15:0] per);
    pattern_sel   = sel;
    inject_period = per;
    enable        = 1'b1;
    @(negedge clock);
    check_vec({tag, "_entry_valid"}, tx_valid, 1'b0);
  endtask

  task automatic stop_run(input string tag);
    enable = 1'b0;
    @(negedge clock);
    check_vec({tag, "_stop_valid"}, tx_valid, 1'b0);
    check_vec({tag, "_stop_data"}, {tx_data, ref_data}, 2'b00);
    check_vec({tag, "_stop_bitcnt"}, bit_count, exp_bits);
    check_vec({tag, "_all_valid"}, n_invalid, 0);
    n_invalid = 0;
  endtask

  initial begin
    logic t, r, v;
    int on_cnt, off_cnt;
    logic [15:0] first15;

    repeat (3) @(negedge clock);
    check_vec("rst_outputs", {tx_data, ref_data, tx_valid, count_full}, 4'b0000);
    check_vec("rst_bitcnt", bit_count, 16'd0);
    check_vec("rst_injcnt", inject_count, 16'd0);
    reset = 1'b0;
    @(negedge clock);

    // PRBS7 from the default seed; period 127 so bit 128 repeats bit 1.
    start_run("prbs7", 2'b00, 16'd0);
    capture(135, '0);
    check_vec("prbs7_bits1_8", rv[7:0], 8'h40);
    check_vec("prbs7_bits128_135", rv[134:127], 8'h40);
    check_vec("prbs7_no_inject", tv[134:0] ^ rv[134:0], 0);
    check_vec("prbs7_bitcnt", bit_count, exp_bits);
    check_vec("prbs7_injcnt", inject_count, exp_inj);
    stop_run("prbs7");
    repeat (2) @(negedge clock);
    check_vec("idle_bitcnt_hold", bit_count, exp_bits);

    // Restart reloads the seed; mid-run select/period changes are ignored.
    start_run("restart", 2'b00, 16'd0);
    pattern_sel   = 2'b10;
    inject_period = 16'd3;
    capture(8, '0);
    check_vec("restart_bits1_8", rv[7:0], 8'h40);
    check_vec("restart_no_inject", tv[7:0] ^ rv[7:0], 0);
    stop_run("restart");

    // Alternating pattern; inject_req high for bits 3..7 then a pulse at bit 10.
    start_run("manual", 2'b11, 16'd0);
    capture(12, 256'h27C);
    exp_inj += 2;
    check_vec("alt_ref", rv[11:0], 12'h555);
    check_vec("manual_diff", tv[11:0] ^ rv[11:0], 12'h204);
    check_vec("manual_injcnt", inject_count, exp_inj);
    stop_run("manual");
    inject_req = 1'b1;
    @(negedge clock);
    inject_req = 1'b0;
    repeat (2) @(negedge clock);
    check_vec("idle_pulse_injcnt", inject_count, exp_inj);

    // Period 4 with a manual edge on bit 4: one inversion, one count.
    start_run("per4", 2'b11, 16'd4);
    capture(4, 256'h8);
    exp_inj += 1;
    check_vec("per4_diff_1_4", tv[3:0] ^ rv[3:0], 4'b1000);
    check_vec("per4_injcnt_bit4", inject_count, exp_inj);
    capture(4, '0);
    exp_inj += 1;
    check_vec("per4_diff_5_8", tv[3:0] ^ rv[3:0], 4'b1000);
    check_vec("per4_injcnt_bit8", inject_count, exp_inj);
    stop_run("per4");

    start_run("prbs9", 2'b01, 16'd0);
    capture(6, '0);
    check_vec("prbs9_bits1_6", rv[5:0], 6'h20);
    stop_run("prbs9");

    // PRBS15 with period 100 over 1000 bits.
    start_run("prbs15", 2'b10, 16'd100);
    inject_period = 16'd7;
    pattern_sel   = 2'b00;
    on_cnt  = 0;
    off_cnt = 0;
    first15 = '0;
    for (int k = 1; k <= 1000; k++) begin
      take_bit(t, r, v);
      if (!v) n_invalid++;
      if (k <= 16) first15[k-1] = r;
      if (t != r) begin
        if (k % 100 == 0) on_cnt++;
        else off_cnt++;
      end
    end
    exp_inj += 10;
    check_vec("prbs15_bits1_16", first15, 16'h4000);
    check_vec("prbs15_inv_on_period", on_cnt, 10);
    check_vec("prbs15_inv_elsewhere", off_cnt, 0);
    check_vec("prbs15_injcnt", inject_count, exp_inj);
    check_vec("prbs15_bitcnt", bit_count, exp_bits);
    stop_run("prbs15");

    // Reset mid-run, deassert with enable held, then run into saturation.
    start_run("rst", 2'b00, 16'd0);
    capture(3, '0);
    #2 reset = 1'b1;
    #1;
    check_vec("rst_mid_outputs", {tx_data, ref_data, tx_valid, count_full}, 4'b0000);
    check_vec("rst_mid_bitcnt", bit_count, 16'd0);
    check_vec("rst_mid_injcnt", inject_count, 16'd0);
    @(negedge clock);
    reset    = 1'b0;
    exp_bits = 0;
    exp_inj  = 0;
    n_invalid = 0;
    @(negedge clock);
    check_vec("rst_entry_valid", tx_valid, 1'b0);
    capture(8, '0);
    check_vec("rst_bits1_8", rv[7:0], 8'h40);
    for (int k = 9; k <= 65540; k++) begin
      take_bit(t, r, v);
      if (!v) n_invalid++;
      if (k == 65534) begin
        check_vec("sat_bitcnt_65534", bit_count, 16'hFFFE);
        check_vec("sat_full_65534", count_full, 1'b0);
      end
      if (k == 65535) begin
        check_vec("sat_bitcnt_65535", bit_count, 16'hFFFF);
        check_vec("sat_full_65535", count_full, 1'b1);
      end
    end
    check_vec("sat_bitcnt_65540", bit_count, exp_bits);
    check_vec("sat_full_65540", count_full, 1'b1);
    check_vec("sat_valid_65540", tx_valid, 1'b1);
    check_vec("sat_injcnt", inject_count, exp_inj);
    stop_run("sat");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bert_pattern_tx.md
BERT_PATTERN_TX -- requirements
Module: bert_pattern_tx

Interface
REQ-001 SHALL have parameter: INIT_SEED, 15'h7FFF, LFSR load value at RUN entry; an all-zero masked seed is replaced by all-ones.
REQ-002 SHALL have port: clock  input  1  rising-edge system clock.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: enable  input  1  transmit enable; also drives the error counter's enable.
REQ-005 SHALL have port: pattern_sel  input  2  pattern select: 00 PRBS7, 01 PRBS9, 10 PRBS15, 11 alternating 1010.
REQ-006 SHALL have port: inject_req  input  1  manual single-bit error injection request.
REQ-007 SHALL have port: inject_period  input  16  periodic injection interval in bits; 0 disables periodic injection.
REQ-008 SHALL have port: tx_data  output  1  transmitted bit, possibly corrupted by injection.
REQ-009 SHALL have port: ref_data  output  1  uncorrupted reference bit for the comparator's expected input.
REQ-010 SHALL have port: tx_valid  output  1  high while tx_data/ref_data carry a generated bit.
REQ-011 SHALL have port: bit_count  output  16  bits sent, saturating.
REQ-012 SHALL have port: inject_count  output  16  errors injected, saturating.
REQ-013 SHALL have port: count_full  output  1  set when either counter reaches 16'hFFFF.

Function
REQ-014 SHALL implement a two-state FSM, IDLE and RUN, with transitions taken on clock edges.
REQ-015 SHALL transition IDLE->RUN when enable=1: load lfsr with INIT_SEED (masked to pattern width), latch pattern_sel and inject_period, clear the period counter, and drive tx_valid=0.
REQ-016 SHALL, in RUN with enable=1, shift once per cycle and register ref_data=fb, tx_data=fb XOR inj, and tx_valid=1; the first valid bit appears 2 edges after enable is sampled high.
REQ-017 SHALL compute fb as: PRBS7 fb=lfsr[6]^lfsr[5]; PRBS9 fb=lfsr[8]^lfsr[4]; PRBS15 fb=lfsr[14]^lfsr[13]; and shift as lfsr <= {lfsr[w-2:0], fb}, where w is the pattern width.
REQ-018 SHALL, in fixed mode (11), output 1,0,1,0,... starting with 1 at RUN entry.
REQ-019 SHALL transition RUN->IDLE when enable=0: at the next edge tx_valid, tx_data and ref_data go to 0, and counters hold their values.
REQ-020 SHALL ignore pattern_sel and inject_period changes during RUN; new values take effect at the next RUN entry.
REQ-021 SHALL inject manually on a rising edge of inject_req sampled in RUN, inverting the next output bit once; holding inject_req high SHALL NOT inject again.
REQ-022 SHALL ignore inject_req edges seen in IDLE.
REQ-023 SHALL inject periodically when inject_period=P>0: invert output bits P, 2P, 3P, ... counted from RUN entry; the period counter wraps to 1 after reaching P.
REQ-024 SHALL treat manual and periodic injection on the same bit as a single inversion (OR, not XOR), incrementing inject_count by 1.
REQ-025 SHALL increment bit_count by 1 per valid bit and saturate at 16'hFFFF.
REQ-026 SHALL increment inject_count by 1 per inverted bit and saturate at 16'hFFFF.
REQ-027 SHALL set count_full at the edge either counter becomes FFFF and hold it until reset; output generation continues regardless.
REQ-028 SHALL keep ref_data and the LFSR sequence unaffected by injection.

Reset
REQ-029 SHALL, on reset assertion, immediately force: state=IDLE, tx_data=0, ref_data=0, tx_valid=0, bit_count=0, inject_count=0, count_full=0, lfsr=INIT_SEED, period counter=0, inject_req edge register=0.
REQ-030 SHALL abort a RUN in progress when reset asserts mid-RUN, with no partial bit emitted.
REQ-031 SHALL, after reset deassertion with enable already high, enter RUN at the first edge and follow REQ-016 latency.

Structure
REQ-032 SHALL place pattern_sel encodings, FSM state encodings, tap positions and default seed in a shared bert_defs package/include used by this block and the error counter.
REQ-033 SHALL implement the LFSR as one sub-module, bert_lfsr (inputs load, shift, sel, seed; outputs fb, state), reusable by a future receive-side sync checker.

Verification
REQ-034 SHALL cover: PRBS7, default seed, enable held high -> ref_data bits 1..8 = 0,0,0,0,0,0,1,0; bit 128 equals bit 1; no injection so tx_data==ref_data.
REQ-035 SHALL cover: PRBS15, inject_period=100, 1000 bits -> exactly bits 100,200,...,1000 differ, inject_count=10, bit_count=1000.
REQ-036 SHALL cover: inject_req held high 5 cycles in RUN, then a second pulse -> exactly 2 inverted bits, inject_count=2; a pulse in IDLE -> inject_count unchanged.
REQ-037 SHALL cover: inject_period=4 with an inject_req edge aligned to bit 4 -> bit 4 inverted once, inject_count=1 at that point.
REQ-038 SHALL cover: enable low mid-run then high -> tx_valid low the edge after, bit_count held, sequence restarts from seed (first bits again 0,0,0,0,0,0,1,0).
REQ-039 SHALL cover: reset pulse mid-RUN, then 65540 valid bits -> all outputs 0 immediately on reset; then bit_count=FFFF and count_full=1 from bit 65535 onward.
